// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// Frame is start, 8 data bits LSB-first, parity, stop.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam int FRAME_BITS = 11;

    function automatic logic parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Scheduler <-> serial transmitter handshake.
// The scheduler drives the master side and the transmitter drives the slave side.
interface uart_tx_scheduler_if;
    logic       tx_send;
    logic [7:0] tx_data;
    logic       tx_parity;
    logic       tx_active_flag;
    logic       tx_done_flag;

    modport master (
        output tx_send, tx_data, tx_parity,
        input  tx_active_flag, tx_done_flag
    );

    modport slave (
        input  tx_send, tx_data, tx_parity,
        output tx_active_flag, tx_done_flag
    );
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or above pointer, wrapping.
// Returns the winner both one-hot and as an index.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      pointer,
    output logic [NUM_REQ-1:0] winner,
    output logic [PW-1:0]      winner_idx,
    output logic               valid
);

    function automatic logic [PW-1:0] slot(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    // Scan from the farthest offset down so the nearest set bit is written last.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[slot(pointer, k)]) begin
                winner                   = '0;
                winner[slot(pointer, k)] = 1'b1;
                winner_idx               = slot(pointer, k);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 11-bit-frame serial transmitter among NUM_REQ sources.
// Drives send/active/done handshake, inserts an inter-frame gap, pulses done to the owner.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter bit PARITY_ODD     = 1'b0,
    parameter int GAP_CYCLES     = 1,
    parameter int LAUNCH_TIMEOUT = 4
) (
    input  logic                   baud_clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic                   err_timeout,
    uart_tx_scheduler_if.master    tx
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = 4;
    localparam logic [CW-1:0] TO_LAST  = CW'(LAUNCH_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t              state;
    logic [PW-1:0]       ptr;
    logic [CW-1:0]       cnt;
    logic [NUM_REQ-1:0]  win;
    logic [PW-1:0]       win_idx;
    logic                win_vld;
    logic [7:0]          win_byte;
    logic [PW-1:0]       ptr_next;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req),
        .pointer    (ptr),
        .winner     (win),
        .winner_idx (win_idx),
        .valid      (win_vld)
    );

    assign win_byte = req_data[{win_idx, 3'b000} +: 8];
    assign ptr_next = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);

    always_ff @(posedge baud_clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            grant        <= '0;
            done         <= '0;
            busy         <= 1'b0;
            err_timeout  <= 1'b0;
            tx.tx_send   <= 1'b0;
            tx.tx_data   <= '0;
            tx.tx_parity <= PARITY_ODD;
        end else begin
            done        <= '0;
            err_timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant        <= win;
                        tx.tx_data   <= win_byte;
                        tx.tx_parity <= parity(win_byte, PARITY_ODD);
                        tx.tx_send   <= 1'b1;
                        ptr          <= ptr_next;
                        cnt          <= '0;
                        busy         <= 1'b1;
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (tx.tx_active_flag) begin
                        tx.tx_send <= 1'b0;
                        state      <= BUSY;
                    end else if (cnt == TO_LAST) begin
                        // Abandon the launch; ptr already moved past this requester.
                        err_timeout <= 1'b1;
                        grant       <= '0;
                        tx.tx_send  <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BUSY: begin
                    if (!tx.tx_active_flag) begin
                        done  <= grant;
                        grant <= '0;
                        cnt   <= '0;
                        if (GAP_CYCLES > 0) begin
                            state <= GAP;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The sticky done flag from the transmitter must agree with active falling.
    a_done_flag: assert property (@(posedge baud_clk) disable iff (reset)
        (state == BUSY && !tx.tx_active_flag) |-> tx.tx_done_flag);

    a_grant_onehot: assert property (@(posedge baud_clk) disable iff (reset)
        $onehot0(grant));

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler with a behavioural transmitter and a frame scoreboard.
// A second instance with odd parity is used only for launch/parity checks.
module tb_uart_tx_scheduler;
    import uart_pkg::*;

    typedef struct { int idx; logic [7:0] data; logic par; } exp_t;
    typedef struct { int idx; logic [7:0] data; logic par_even; logic par_odd; } vec_t;

    logic        baud_clk = 1'b0;
    logic        reset, tx_en, line, act_int;
    logic [3:0]  req, grant, done, req_o, grant_o, done_o, bitn, pg;
    logic [31:0] req_data, req_data_o;
    logic        busy, err_timeout, busy_o, err_o, rise;
    logic [10:0] frm, rxf;
    int          rxn, errs, checks, dones, errs_to, cyc;
    exp_t        sbq[$];
    vec_t        vt[5];

    uart_tx_scheduler_if txb();
    uart_tx_scheduler_if txo();

    uart_tx_scheduler #(.NUM_REQ(4), .PARITY_ODD(1'b0), .GAP_CYCLES(1), .LAUNCH_TIMEOUT(4)) dut (
        .baud_clk(baud_clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .busy(busy), .err_timeout(err_timeout), .tx(txb));

    uart_tx_scheduler #(.NUM_REQ(4), .PARITY_ODD(1'b1), .GAP_CYCLES(1), .LAUNCH_TIMEOUT(4)) dut_odd (
        .baud_clk(baud_clk), .reset(reset), .req(req_o), .req_data(req_data_o),
        .grant(grant_o), .done(done_o), .busy(busy_o), .err_timeout(err_o), .tx(txo));

    assign txo.tx_active_flag = 1'b0;
    assign txo.tx_done_flag   = 1'b0;

    always #5 baud_clk = ~baud_clk;

    // Transmitter model: accepts send one edge later, active_flag high for 11 bit times.
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            act_int <= 1'b0; bitn <= '0; frm <= '0; line <= 1'b1;
            txb.tx_active_flag <= 1'b0; txb.tx_done_flag <= 1'b0;
        end else if (act_int) begin
            line <= frm[bitn];
            txb.tx_active_flag <= 1'b1;
            bitn <= bitn + 4'd1;
            if (bitn == 4'd10) begin
                act_int <= 1'b0;
                txb.tx_done_flag <= 1'b1;
            end
        end else begin
            txb.tx_active_flag <= 1'b0;
            line <= 1'b1;
            if (tx_en && txb.tx_send) begin
                act_int <= 1'b1; bitn <= '0;
                frm <= {1'b1, txb.tx_parity, txb.tx_data, 1'b0};
                txb.tx_done_flag <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One baud cycle: sample after the edge, collect serial bits, score completed frames.
    task automatic tick();
        exp_t e;
        pg = grant;
        @(posedge baud_clk); #1;
        cyc++;
        rise = (grant != 4'd0) && (pg == 4'd0);
        if (txb.tx_active_flag === 1'b1) begin
            rxf = {line, rxf[10:1]};
            rxn++;
        end
        if (err_timeout === 1'b1) errs_to++;
        chk("grant_onehot0", 32'($onehot0(grant)), 1);
        if (done != 4'd0) begin
            dones++;
            chk("done_on_owner", 32'(done & ~pg), 0);
            if (sbq.size() == 0) begin
                checks++; errs++;
                $display("FAIL unexpected_done: done=%b with empty scoreboard", done);
            end else begin
                e = sbq.pop_front();
                chk("done_idx", 32'(done), 1 << e.idx);
                chk("frame_len", rxn, FRAME_BITS);
                chk("frame_bits", 32'(rxf), 32'({1'b1, e.par, e.data, 1'b0}));
            end
            rxn = 0;
        end
    endtask

    task automatic wait_rise(input string name, input int limit);
        int n;
        n = 0;
        do begin tick(); n++; end while (!rise && n < limit);
        if (!rise) begin
            checks++; errs++;
            $display("FAIL %s: no grant within %0d cycles", name, limit);
        end
    endtask

    initial begin
        int d0, t0, last;
        vt[0] = '{0, 8'h07, 1'b1, 1'b0};
        vt[1] = '{0, 8'h03, 1'b0, 1'b1};
        vt[2] = '{1, 8'h41, 1'b0, 1'b1};
        vt[3] = '{3, 8'hFF, 1'b0, 1'b1};
        vt[4] = '{2, 8'h80, 1'b1, 1'b0};
        errs = 0; checks = 0; dones = 0; errs_to = 0; cyc = 0; rxn = 0; rxf = '0; rise = 1'b0;
        reset = 1'b1; tx_en = 1'b1;
        req = '0; req_o = '0; req_data = '0; req_data_o = '0;

        // Reset state
        tick(); tick();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_send", 32'(txb.tx_send), 0);
        chk("rst_data", 32'(txb.tx_data), 0);
        chk("rst_par_even", 32'(txb.tx_parity), 0);
        chk("rst_par_odd", 32'(txo.tx_parity), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_timeout), 0);
        reset = 1'b0;
        tick();

        // Single request, full latency walk
        req = 4'b0001; req_data = 32'h0000_0041; sbq.push_back('{0, 8'h41, 1'b0});
        d0 = dones;
        tick();
        chk("single_grant", 32'(grant), 1);
        chk("single_send", 32'(txb.tx_send), 1);
        chk("single_busy", 32'(busy), 1);
        chk("single_data", 32'(txb.tx_data), 32'h41);
        chk("single_par", 32'(txb.tx_parity), 0);
        req = '0; req_data = 32'hFFFF_FFFF;
        tick(); tick();
        chk("single_send_held", 32'(txb.tx_send), 1);
        tick();
        chk("single_send_drop", 32'(txb.tx_send), 0);
        repeat (10) tick();
        chk("single_no_early_done", 32'(done), 0);
        chk("single_data_stable", 32'(txb.tx_data), 32'h41);
        tick();
        chk("single_done", 32'(done), 1);
        chk("single_done_cnt", dones, d0 + 1);
        chk("single_grant_clr", 32'(grant), 0);
        tick(); tick();
        chk("single_idle", 32'(busy), 0);

        // Parity/data vectors on both instances
        for (int i = 0; i < 5; i++) begin
            req_data = 32'hA5A5_A5A5;
            req_data[8*vt[i].idx +: 8] = vt[i].data;
            req_data_o = req_data;
            req = 4'(1 << vt[i].idx); req_o = req;
            sbq.push_back('{vt[i].idx, vt[i].data, vt[i].par_even});
            d0 = dones;
            tick();
            chk("vec_grant", 32'(grant), 1 << vt[i].idx);
            chk("vec_grant_odd", 32'(grant_o), 1 << vt[i].idx);
            chk("vec_data", 32'(txb.tx_data), 32'(vt[i].data));
            chk("vec_par_even", 32'(txb.tx_parity), 32'(vt[i].par_even));
            chk("vec_par_odd", 32'(txo.tx_parity), 32'(vt[i].par_odd));
            req = '0; req_o = '0;
            repeat (4) tick();
            chk("vec_odd_timeout", 32'(err_o), 1);
            repeat (11) tick();
            chk("vec_done", dones, d0 + 1);
        end

        // Launch timeout, then retry of the same requester
        tx_en = 1'b0; req = 4'b0010; req_data = 32'h0000_5A00;
        sbq.push_back('{1, 8'h5A, 1'b0});
        d0 = dones; t0 = errs_to;
        tick();
        chk("to_grant", 32'(grant), 2);
        repeat (3) tick();
        chk("to_send_held", 32'(txb.tx_send), 1);
        chk("to_no_err_yet", 32'(err_timeout), 0);
        tick();
        chk("to_err", 32'(err_timeout), 1);
        chk("to_grant_clr", 32'(grant), 0);
        chk("to_send_clr", 32'(txb.tx_send), 0);
        chk("to_no_done", dones, d0);
        tick();
        chk("to_regrant", 32'(grant), 2);
        chk("to_err_pulse", 32'(err_timeout), 0);
        tx_en = 1'b1; req = '0;
        repeat (16) tick();
        chk("to_done_after_retry", dones, d0 + 1);
        chk("to_pulse_count", errs_to, t0 + 1);

        // Reset in the middle of a frame
        req = 4'b0001; req_data = 32'h0000_003C; d0 = dones;
        tick();
        chk("mid_grant", 32'(grant), 1);
        req = '0;
        repeat (5) tick();
        reset = 1'b1; req = 4'b0100; req_data = 32'h00C3_0000;
        tick();
        chk("mid_rst_grant", 32'(grant), 0);
        chk("mid_rst_send", 32'(txb.tx_send), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        reset = 1'b0; rxn = 0;
        sbq.push_back('{2, 8'hC3, 1'b0});
        tick();
        chk("mid_regrant", 32'(grant), 4);
        req = '0;
        repeat (15) tick();
        chk("mid_done_cnt", dones, d0 + 1);

        // Late request waits for BUSY and GAP to finish
        req = 4'b0001; req_data = 32'h0069_0096; d0 = dones;
        sbq.push_back('{0, 8'h96, 1'b0});
        sbq.push_back('{2, 8'h69, 1'b0});
        tick();
        chk("late_grant0", 32'(grant), 1);
        req = '0;
        repeat (5) tick();
        req = 4'b0100;
        repeat (9) tick();
        chk("late_first_done", dones, d0 + 1);
        tick();
        chk("late_wait_gap", 32'(grant), 0);
        tick();
        chk("late_grant2", 32'(grant), 4);
        req = '0;
        repeat (15) tick();
        chk("late_done_cnt", dones, d0 + 2);

        // All requesting from a fresh pointer: 0,1,2,3,0 at fixed spacing
        reset = 1'b1; tick(); tick(); reset = 1'b0; rxn = 0;
        req = 4'hF; req_data = 32'h4332_2110; d0 = dones; last = 0;
        sbq.push_back('{0, 8'h10, 1'b1});
        sbq.push_back('{1, 8'h21, 1'b0});
        sbq.push_back('{2, 8'h32, 1'b1});
        sbq.push_back('{3, 8'h43, 1'b1});
        sbq.push_back('{0, 8'h10, 1'b1});
        for (int k = 0; k < 5; k++) begin
            wait_rise("rr_grant", 20);
            chk("rr_order", 32'(grant), 1 << (k % 4));
            if (k > 0) chk("rr_spacing", cyc - last, 16);
            last = cyc;
            if (k == 4) req = '0;
        end
        repeat (16) tick();
        chk("rr_done_cnt", dones, d0 + 5);
        chk("sb_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one 11-bit-frame serial transmitter (start, 8 data LSB-first, parity, stop) among NUM_REQ requesters.
- Round-robin picks one pending request, captures its byte, and computes parity.
- Sequences the transmitter's send / active_flag / done_flag handshake, enforces an inter-frame gap, and returns a per-requester completion pulse.
- Sits between the cold-storage telemetry sources and the transmitter, all on the baud clock domain.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity.
- GAP_CYCLES, 1: idle-line baud cycles inserted after each frame, 0..15.
- LAUNCH_TIMEOUT, 4: cycles allowed in LAUNCH for tx_active_flag to rise, 2..15.

Ports:
- baud_clk  in  1  clock; all logic on its rising edge.
- reset  in  1  reset; synchronous, active-high.
- req  in  NUM_REQ  per-requester request level; held until grant.
- req_data  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
- grant  out  NUM_REQ  one-hot owner, high from LAUNCH entry until done.
- done  out  NUM_REQ  one-cycle pulse on owner when its frame completes.
- tx_send  out  1  to transmitter send.
- tx_data  out  8  to transmitter data_in; stable for the whole frame.
- tx_parity  out  1  to transmitter parity_bit.
- tx_active_flag  in  1  from transmitter.
- tx_done_flag  in  1  from transmitter; sticky, used only as a cross-check.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  one-cycle pulse when a launch is aborted.

Behaviour:
- Reset values: state IDLE, grant=0, done=0, tx_send=0, tx_data=0, tx_parity=PARITY_ODD, busy=0, err_timeout=0, rr pointer=0, counters=0.
- Reset mid-frame drops ownership immediately with no done pulse. Top level ties transmitter reset_n = ~reset.
- States: IDLE, LAUNCH, BUSY, GAP.
- IDLE:
  - If any req is set, pick the winner: first set bit scanning upward from the rr pointer, wrapping.
  - On the next edge: grant[winner]=1, capture tx_data=req_data[winner], tx_parity = XOR-reduce(byte) ^ PARITY_ODD, tx_send=1, go to LAUNCH.
  - Set the rr pointer to (winner+1) mod NUM_REQ.
- LAUNCH:
  - Hold tx_send=1 until tx_active_flag=1 is sampled, then tx_send=0 and go to BUSY.
  - If LAUNCH_TIMEOUT cycles pass without tx_active_flag: err_timeout pulse, grant=0, tx_send=0, no done pulse, go to IDLE.
  - The rr pointer stays advanced, so a failed requester retries after the others.
- BUSY:
  - On the first sampled tx_active_flag=0: done[owner] pulse for 1 cycle, grant=0.
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
  - tx_done_flag is expected to be 1 at that sample; a mismatch is a simulation assertion only, not a functional input.
- GAP: count GAP_CYCLES cycles with tx_send=0, then go to IDLE.
- tx_data and tx_parity change only on IDLE->LAUNCH. A requester may change req_data once grant is seen.
- A requester dropping req after grant does not abort its frame.
- A requester dropping req before grant is never granted.
- A new request arriving during BUSY or GAP waits. There is no preemption.
- Latency with the transmitter attached: grant rises at edge 0, transmitter enters ACTIVE at edge 1, active_flag is high at edges 2..12 and falls at edge 13. done pulses at edge 14. The next grant comes at edge 15+GAP_CYCLES.
- Throughput per frame: 15+GAP_CYCLES baud cycles.
- grant and done are always one-hot or zero, and done is only ever set on the current grant bit.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, LAUNCH, BUSY, GAP);
  - FRAME_BITS=11;
  - parity function (byte, odd) -> bit.
- Sub-module rr_arbiter:
  - parameterised NUM_REQ; inputs req and pointer;
  - outputs a one-hot winner and a valid flag;
  - purely combinational, instantiated once.

Test Plan:
- Single request: req=0001, req_data[7:0]=0x41, GAP_CYCLES=1 -> grant=0001 at edge 0, serial line shows 0,1,0,0,0,0,0,1,0, parity 0, stop 1; done=0001 at edge 14; busy low at edge 16.
- All requesting: req=1111 held, data 0x10/0x21/0x32/0x43 -> grants in order 0,1,2,3,0, each 16 cycles apart, each frame carries its own byte.
- Parity: PARITY_ODD=1, byte 0x07 -> tx_parity=0; byte 0x03 -> tx_parity=1. Repeat with PARITY_ODD=0 -> inverted values.
- Timeout: tx_active_flag tied 0, req=0010 -> tx_send high 4 cycles, err_timeout pulse, grant=0, no done pulse, re-grant of requester 1 on the next IDLE.
- Reset mid-frame: assert reset at edge 6 -> next edge grant=0, tx_send=0, busy=0, no done. After release, a pending req=0100 is granted with a full frame.
- Late request: req[2] rises during BUSY of requester 0 -> req[2] is not granted until after GAP; the requester 0 frame is unaffected.
